// File: rtl/mem_wb_skid_pkg.sv
// Shared definitions for the MEM/WB skid stage: default widths, stall bit
// names, canonical zero values and the occupancy encoding.
package mem_wb_skid_pkg;

  localparam int CH_DEF      = 2;
  localparam int AW_DEF      = 5;
  localparam int DW_DEF      = 32;
  localparam int STALL_W_DEF = 6;

  localparam int STALL_MEMWB = 3;

  localparam logic [AW_DEF-1:0] NOPRegAddr = 5'b00000;
  localparam logic [DW_DEF-1:0] ZeroWord   = 32'h0000_0000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

endpackage

// File: rtl/mem_wb_skid_sanitise.sv
// Combinational write-request cleanup for one writeback bundle: drops x0
// writes and, on duplicate destinations, keeps only the highest channel.
module wb_bundle_sanitise
  import mem_wb_skid_pkg::*;
#(
  parameter int CH = CH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [CH-1:0]    req,
  input  logic [CH*AW-1:0] addr,
  output logic [CH-1:0]    req_clean
);

  // Later channels are younger in program order, so they win a conflict.
  always_comb begin
    req_clean = {CH{1'b0}};
    for (int i = 0; i < CH; i++) begin
      req_clean[i] = req[i] && (addr[i*AW +: AW] != AW'(NOPRegAddr));
      for (int j = i + 1; j < CH; j++) begin
        if (req[j] && (addr[j*AW +: AW] == addr[i*AW +: AW])) begin
          req_clean[i] = 1'b0;
        end else begin
          req_clean[i] = req_clean[i];
        end
      end
    end
  end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline stage with a valid/ready handshake and a two-entry
// (main + skid) buffer carrying CH register writeback channels per bundle.
module mem_wb_skid
  import mem_wb_skid_pkg::*;
#(
  parameter int CH        = CH_DEF,
  parameter int AW        = AW_DEF,
  parameter int DW        = DW_DEF,
  parameter int STALL_W   = STALL_W_DEF,
  parameter int STALL_BIT = STALL_MEMWB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               flush,
  input  logic [STALL_W-1:0] stall_state,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CH-1:0]      in_w_req,
  input  logic [CH*AW-1:0]   in_w_addr,
  input  logic [CH*DW-1:0]   in_w_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CH-1:0]      wb_w_req,
  output logic [CH*AW-1:0]   wb_w_addr,
  output logic [CH*DW-1:0]   wb_w_data,
  output logic [1:0]         occ
);

  logic             main_valid_r, skid_valid_r, rst_done_r;
  logic [CH-1:0]    main_req_r, skid_req_r;
  logic [CH*AW-1:0] main_addr_r, skid_addr_r;
  logic [CH*DW-1:0] main_data_r, skid_data_r;

  logic             main_valid_nxt_s, skid_valid_nxt_s;
  logic [CH-1:0]    main_req_nxt_s, skid_req_nxt_s;
  logic [CH*AW-1:0] main_addr_nxt_s, skid_addr_nxt_s;
  logic [CH*DW-1:0] main_data_nxt_s, skid_data_nxt_s;

  logic [CH-1:0] san_req_s;
  logic          frz_s, flush_s, push_s, pop_s, in_ready_s;
  logic          unused_stall_s;
  occ_e          occ_state_s;

  wb_bundle_sanitise #(.CH(CH), .AW(AW)) u_sanitise (
    .req       (in_w_req),
    .addr      (in_w_addr),
    .req_clean (san_req_s)
  );

  assign unused_stall_s = ^stall_state;

  assign frz_s      = !rdy || stall_state[STALL_BIT];
  assign flush_s    = flush && rdy;
  // rst_done_r keeps in_ready low until the first edge after reset release.
  assign in_ready_s = rst_done_r && !skid_valid_r && !frz_s;
  assign push_s     = in_valid && in_ready_s;
  assign pop_s      = main_valid_r && out_ready && !frz_s;

  assign occ_state_s = skid_valid_r ? OCC_TWO : (main_valid_r ? OCC_ONE : OCC_EMPTY);

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_r;
  assign wb_w_req  = main_req_r & {CH{main_valid_r}};
  assign wb_w_addr = main_addr_r;
  assign wb_w_data = main_data_r;
  assign occ       = occ_state_s;

  // Next buffer contents from flush, freeze and the push/pop handshake.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    main_req_nxt_s   = main_req_r;
    main_addr_nxt_s  = main_addr_r;
    main_data_nxt_s  = main_data_r;
    skid_valid_nxt_s = skid_valid_r;
    skid_req_nxt_s   = skid_req_r;
    skid_addr_nxt_s  = skid_addr_r;
    skid_data_nxt_s  = skid_data_r;
    if (flush_s) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
      main_req_nxt_s   = {CH{1'b0}};
      skid_req_nxt_s   = {CH{1'b0}};
    end else if (frz_s) begin
      main_valid_nxt_s = main_valid_r;
    end else begin
      case (occ_state_s)
        OCC_EMPTY: begin
          if (push_s) begin
            main_valid_nxt_s = 1'b1;
            main_req_nxt_s   = san_req_s;
            main_addr_nxt_s  = in_w_addr;
            main_data_nxt_s  = in_w_data;
          end else begin
            main_valid_nxt_s = 1'b0;
          end
        end
        OCC_ONE: begin
          if (push_s && !pop_s) begin
            skid_valid_nxt_s = 1'b1;
            skid_req_nxt_s   = san_req_s;
            skid_addr_nxt_s  = in_w_addr;
            skid_data_nxt_s  = in_w_data;
          end else if (push_s) begin
            main_req_nxt_s  = san_req_s;
            main_addr_nxt_s = in_w_addr;
            main_data_nxt_s = in_w_data;
          end else if (pop_s) begin
            main_valid_nxt_s = 1'b0;
          end else begin
            main_valid_nxt_s = main_valid_r;
          end
        end
        OCC_TWO: begin
          if (pop_s) begin
            main_req_nxt_s   = skid_req_r;
            main_addr_nxt_s  = skid_addr_r;
            main_data_nxt_s  = skid_data_r;
            skid_valid_nxt_s = 1'b0;
          end else begin
            skid_valid_nxt_s = skid_valid_r;
          end
        end
        default: begin
          main_valid_nxt_s = 1'b0;
          skid_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Buffer state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_done_r   <= 1'b0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      main_req_r   <= {CH{1'b0}};
      skid_req_r   <= {CH{1'b0}};
      main_addr_r  <= {CH{AW'(NOPRegAddr)}};
      skid_addr_r  <= {CH{AW'(NOPRegAddr)}};
      main_data_r  <= {CH{DW'(ZeroWord)}};
      skid_data_r  <= {CH{DW'(ZeroWord)}};
    end else begin
      rst_done_r   <= 1'b1;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      main_req_r   <= main_req_nxt_s;
      skid_req_r   <= skid_req_nxt_s;
      main_addr_r  <= main_addr_nxt_s;
      skid_addr_r  <= skid_addr_nxt_s;
      main_data_r  <= main_data_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_wb_skid.sv
// Directed self-checking bench for mem_wb_skid: reset, handshake, freeze,
// sanitising, flush and asynchronous reset scenarios.
module tb_mem_wb_skid;

  localparam int CH = 2;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int SW = 6;

  logic             clk, rst, rdy, flush, in_valid, in_ready, out_valid, out_ready;
  logic [SW-1:0]    stall_state;
  logic [CH-1:0]    in_w_req, wb_w_req;
  logic [CH*AW-1:0] in_w_addr, wb_w_addr;
  logic [CH*DW-1:0] in_w_data, wb_w_data;
  logic [1:0]       occ;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_skid #(.CH(CH), .AW(AW), .DW(DW), .STALL_W(SW), .STALL_BIT(3)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .stall_state(stall_state),
    .in_valid(in_valid), .in_ready(in_ready), .in_w_req(in_w_req),
    .in_w_addr(in_w_addr), .in_w_data(in_w_data), .out_valid(out_valid),
    .out_ready(out_ready), .wb_w_req(wb_w_req), .wb_w_addr(wb_w_addr),
    .wb_w_data(wb_w_data), .occ(occ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input logic v, input logic [1:0] req, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [31:0] d0, input logic [31:0] d1);
    in_valid  = v;
    in_w_req  = req;
    in_w_addr = {a1, a0};
    in_w_data = {d1, d0};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #2;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL rst_occ: got %0d expected 0", occ); end
    n_checks++; if (wb_w_req !== 2'b00) begin n_fail++; $display("FAIL rst_wb_req: got %b expected 00", wb_w_req); end
    n_checks++; if (wb_w_addr !== 10'd0) begin n_fail++; $display("FAIL rst_wb_addr: got %h expected 0", wb_w_addr); end
    n_checks++; if (wb_w_data !== 64'd0) begin n_fail++; $display("FAIL rst_wb_data: got %h expected 0", wb_w_data); end
    tick;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_held_in_ready: got %b expected 0", in_ready); end
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_in_ready: got %b expected 0", in_ready); end
    tick;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_after_edge_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0);
    tick;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_out_valid: got %b expected 1", out_valid); end
    n_checks++; if (wb_w_req !== 2'b01) begin n_fail++; $display("FAIL basic_wb_req: got %b expected 01", wb_w_req); end
    n_checks++; if (wb_w_addr !== 10'd5) begin n_fail++; $display("FAIL basic_wb_addr: got %h expected 005", wb_w_addr); end
    n_checks++; if (wb_w_data !== 64'h0000_0000_DEAD_BEEF) begin n_fail++; $display("FAIL basic_wb_data: got %h expected deadbeef", wb_w_data); end
    n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL basic_occ1: got %0d expected 1", occ); end
    tick;
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL basic_occ0: got %0d expected 0", occ); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 5'd1, 5'd2, 32'hA0, 32'hA1);
    tick;
    n_checks++; if (occ !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_a: got occ=%0d rdy=%b expected occ=1 rdy=1", occ, in_ready); end
    drive(1'b1, 2'b01, 5'd3, 5'd0, 32'hB0, 32'h0);
    tick;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL bp_occ2: got %0d expected 2", occ); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready: got %b expected 0", in_ready); end
    n_checks++; if (wb_w_addr !== {5'd2, 5'd1} || wb_w_data !== {32'hA1, 32'hA0}) begin n_fail++; $display("FAIL bp_head_a: got %h/%h expected A", wb_w_addr, wb_w_data); end
    n_checks++; if (wb_w_req !== 2'b11) begin n_fail++; $display("FAIL bp_head_a_req: got %b expected 11", wb_w_req); end
    out_ready = 1'b1;
    tick;
    n_checks++; if (occ !== 2'd1 || in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_after_pop_a: got occ=%0d rdy=%b expected occ=1 rdy=1", occ, in_ready); end
    n_checks++; if (wb_w_addr !== {5'd0, 5'd3} || wb_w_data !== {32'h0, 32'hB0} || wb_w_req !== 2'b01) begin n_fail++; $display("FAIL bp_head_b: got %h/%h/%b expected B", wb_w_addr, wb_w_data, wb_w_req); end
    tick;
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drained: got occ=%0d v=%b expected 0/0", occ, out_valid); end
  endtask

  task automatic test_freeze(input logic use_rdy);
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd10, 5'd0, 32'hC0, 32'h0);
    tick;
    drive(1'b1, 2'b01, 5'd11, 5'd0, 32'hD0, 32'h0);
    out_ready = 1'b1;
    if (use_rdy) rdy = 1'b0;
    else stall_state[3] = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL frz%0d_in_ready: got %b expected 0", use_rdy, in_ready); end
    for (int k = 0; k < 3; k++) begin
      tick;
      n_checks++; if (occ !== 2'd1 || out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL frz%0d_hold_%0d: got occ=%0d v=%b rdy=%b expected 1/1/0", use_rdy, k, occ, out_valid, in_ready); end
      n_checks++; if (wb_w_addr !== 10'd10 || wb_w_data !== 64'hC0 || wb_w_req !== 2'b01) begin n_fail++; $display("FAIL frz%0d_head_%0d: got %h/%h/%b expected C", use_rdy, k, wb_w_addr, wb_w_data, wb_w_req); end
    end
    rdy = 1'b1;
    stall_state = '0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick;
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL frz%0d_release_occ: got %0d expected 0", use_rdy, occ); end
  endtask

  task automatic test_sanitise;
    out_ready = 1'b1;
    drive(1'b1, 2'b11, 5'd7, 5'd7, 32'h11, 32'h22);
    tick;
    n_checks++; if (wb_w_req !== 2'b10) begin n_fail++; $display("FAIL san_conflict: got %b expected 10", wb_w_req); end
    n_checks++; if (wb_w_addr !== {5'd7, 5'd7} || wb_w_data !== {32'h22, 32'h11}) begin n_fail++; $display("FAIL san_payload: got %h/%h expected unchanged", wb_w_addr, wb_w_data); end
    drive(1'b1, 2'b11, 5'd0, 5'd9, 32'h33, 32'h44);
    tick;
    n_checks++; if (wb_w_req !== 2'b10) begin n_fail++; $display("FAIL san_x0: got %b expected 10", wb_w_req); end
    drive(1'b1, 2'b11, 5'd4, 5'd6, 32'h55, 32'h66);
    tick;
    n_checks++; if (wb_w_req !== 2'b11 || occ !== 2'd1) begin n_fail++; $display("FAIL san_distinct: got %b occ=%0d expected 11 occ=1", wb_w_req, occ); end
    drive(1'b1, 2'b10, 5'd0, 5'd0, 32'h77, 32'h88);
    tick;
    n_checks++; if (wb_w_req !== 2'b00 || out_valid !== 1'b1) begin n_fail++; $display("FAIL san_x0_ch1: got %b v=%b expected 00 v=1", wb_w_req, out_valid); end
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    tick;
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL san_drained: got %0d expected 0", occ); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd1, 5'd0, 32'hA0, 32'h0);
    tick;
    drive(1'b1, 2'b01, 5'd2, 5'd0, 32'hB0, 32'h0);
    tick;
    drive(1'b1, 2'b01, 5'd3, 5'd0, 32'hF0, 32'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0 || wb_w_req !== 2'b00) begin n_fail++; $display("FAIL flush_full: got occ=%0d v=%b req=%b expected 0/0/00", occ, out_valid, wb_w_req); end
    tick;
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL flush_full_not_stored: got %0d expected 0", occ); end
    drive(1'b1, 2'b01, 5'd1, 5'd0, 32'hA0, 32'h0);
    tick;
    drive(1'b1, 2'b01, 5'd3, 5'd0, 32'hF0, 32'h0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    n_checks++; if (occ !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_push: got occ=%0d v=%b expected 0/0", occ, out_valid); end
    drive(1'b1, 2'b01, 5'd1, 5'd0, 32'hA0, 32'h0);
    tick;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    stall_state[3] = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    stall_state = '0;
    n_checks++; if (occ !== 2'd0 || wb_w_req !== 2'b00) begin n_fail++; $display("FAIL flush_stall: got occ=%0d req=%b expected 0/00", occ, wb_w_req); end
  endtask

  task automatic test_async_reset;
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 5'd1, 5'd0, 32'hA0, 32'h0);
    tick;
    drive(1'b1, 2'b01, 5'd2, 5'd0, 32'hB0, 32'h0);
    tick;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("FAIL arst_pre_occ: got %0d expected 2", occ); end
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || wb_w_req !== 2'b00) begin n_fail++; $display("FAIL arst_immediate: got v=%b req=%b expected 0/00", out_valid, wb_w_req); end
    n_checks++; if (occ !== 2'd0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL arst_occ_rdy: got occ=%0d rdy=%b expected 0/0", occ, in_ready); end
    #2 rst = 1'b1;
    tick;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL arst_in_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 5'd5, 5'd0, 32'h1234_5678, 32'h0);
    tick;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    n_checks++; if (out_valid !== 1'b1 || wb_w_req !== 2'b01 || wb_w_addr !== 10'd5 || wb_w_data !== 64'h1234_5678) begin n_fail++; $display("FAIL arst_first_push: got v=%b %b %h %h expected 1 01 005 12345678", out_valid, wb_w_req, wb_w_addr, wb_w_data); end
    tick;
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("FAIL arst_drained: got %0d expected 0", occ); end
  endtask

  initial begin
    rst = 1'b0;
    rdy = 1'b1;
    flush = 1'b0;
    stall_state = '0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0);
    test_reset;
    test_basic;
    test_back_to_back;
    test_freeze(1'b0);
    test_freeze(1'b1);
    test_sanitise;
    test_flush;
    test_async_reset;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
- Parametrised successor of the single-channel MEM/WB pipeline register. Carries CH register-writeback channels (dual-issue ready).
- Replaces the bare stall-hold with a valid/ready handshake backed by a 2-entry skid buffer (main + skid). Adds synchronous flush, x0-write suppression and intra-bundle write-conflict resolution.
- Sits between the MEM stage and the register file / forwarding network.

Parameters:
- CH, 2, number of writeback channels per bundle.
- AW, 5, register address width.
- DW, 32, register data width.
- STALL_W, 6, width of the global stall vector.
- STALL_BIT, 3, stall_state bit that freezes this stage.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rdy  in  1  global ready; when 0, all state holds and no handshake completes.
- flush  in  1  synchronous clear of all buffered bundles.
- stall_state  in  STALL_W  global stall vector.
- in_valid  in  1  MEM bundle valid.
- in_ready  out  1  stage can accept a bundle.
- in_w_req  in  CH  per-channel write request.
- in_w_addr  in  CH*AW  per-channel destination; channel i occupies [i*AW +: AW].
- in_w_data  in  CH*DW  per-channel write data.
- out_valid  out  1  WB bundle valid.
- out_ready  in  1  register file consumes the bundle.
- wb_w_req  out  CH  write enables, gated by out_valid.
- wb_w_addr  out  CH*AW  destinations of the head bundle.
- wb_w_data  out  CH*DW  data of the head bundle.
- occ  out  2  buffered bundle count, 0..2.

Behaviour:
- Reset (rst=0, asynchronous): both entries invalid, stored req/addr/data cleared to 0, occ=0. Outputs: out_valid=0, wb_w_req=0, wb_w_addr=0, wb_w_data=0. in_ready=0 while reset is held; in_ready=1 from the first clock after release.
- Freeze condition: frz = !rdy || stall_state[STALL_BIT]. While frz=1, no push or pop occurs and all registers hold. out_valid and wb_* still show the held head bundle. in_ready is forced 0.
- in_ready = !skid_valid && !frz. It depends only on registered state, never on in_valid.
- push = in_valid && in_ready. pop = out_valid && out_ready && !frz.
- Capture sanitising, applied before storing:
  - Channel i with addr==0 has req cleared.
  - If channels i<j both request the same addr, req[i] is cleared (higher index wins, matching program order).
  - Data and addr are stored unchanged.
- Occupancy transitions:
  - occ 0: push → main.
  - occ 1, push && pop: new bundle → main.
  - occ 1, push && !pop: new bundle → skid.
  - occ 1, pop only: empty.
  - occ 2, pop: skid → main; in_ready rises next cycle.
  - occ 2: push is impossible.
- Latency: a push at cycle n is visible on wb_* at n+1 when occ was 0.
- Throughput: one bundle per cycle with out_ready held at 1.
- wb_w_req = main.req & {CH{out_valid}}. wb_w_addr and wb_w_data always drive main contents.
- flush=1 (when rdy=1): both entries invalidated and req cleared at the next edge. Flush overrides push/pop in the same cycle and overrides stall. Addr/data need not be cleared.
- Reset asserted mid-operation discards all bundles immediately, without waiting for a clock edge.

Decomposition:
- Shared package / defines file holds:
  - Default AW, DW, STALL_W.
  - Stall bit index names, e.g. STALL_MEMWB=3.
  - NOPRegAddr and ZeroWord.
- One natural sub-module: wb_bundle_sanitise. Combinational, CH-parametrised; implements x0 suppression and conflict masking. Instantiated once on the input path.
- Skid control stays in the top module.

Test Plan:
- Reset/basic: release rst, push ch0 {req=1, addr=5, data=0xDEADBEEF} with out_ready=1 → next cycle out_valid=1, wb_w_req=2'b01, addr 5, data 0xDEADBEEF; occ returns to 0 after the pop.
- Backpressure: out_ready=0, push bundles A, B → occ=2, in_ready=0, head=A. Raise out_ready → A, then B, on consecutive cycles. in_ready=1 one cycle after A pops. No loss or duplication.
- Stall/rdy freeze: stall_state[3]=1 for 3 cycles with in_valid=1 and occ=1 → in_ready=0, occ stays 1, wb_* constant. Same check with rdy=0.
- Sanitise: ch0 {req=1, addr=7}, ch1 {req=1, addr=7} → wb_w_req=2'b10. ch0 addr=0, req=1 → wb_w_req[0]=0.
- Flush: occ=2, assert flush together with in_valid=1 → next cycle occ=0, out_valid=0, wb_w_req=0, and the incoming bundle is not stored.
- Async reset mid-stream: drop rst between edges with occ=2 → out_valid=0 and wb_w_req=0 immediately, without a clock edge. After release, first push is delivered normally.
